// File: rtl/sensor_cond_gen.sv
// Multi-channel sensor conditioning: one shared exponential-averaging datapath
// scanned across NUM_CH channels per sample tick, plus cadence debounce and period timer.
module sensor_cond_gen #(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 12,
   parameter int AVG_SHIFT   = 4,
   parameter int TICK_LOG2   = 16,
   parameter int CAD_STABLE  = 1024,
   parameter int PED_TIMEOUT = (1 << 22) - 1,
   parameter int PER_W       = 22,
   parameter int FAST_SIM    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] sens_in,
   input  logic                    cadence_raw,
   output logic [NUM_CH*WIDTH-1:0] avg_out,
   output logic                    avg_vld,
   output logic                    cad_edge,
   output logic [PER_W-1:0]        cad_period,
   output logic                    not_pedaling
);

   localparam int TICK_L = (FAST_SIM != 0) ? 4 : TICK_LOG2;
   localparam int CAD_ST = (FAST_SIM != 0) ? 2 : CAD_STABLE;
   localparam int PED_TO = (FAST_SIM != 0) ? 1024 : PED_TIMEOUT;
   localparam int ACC_W  = WIDTH + AVG_SHIFT;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int FLT_W  = $clog2(CAD_ST + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [TICK_L-1:0] tick_cnt_r;
   logic              tick_r;
   state_t            state_r, state_s;
   logic [CH_W-1:0]   ch_r, ch_s;
   logic [ACC_W-1:0]  acc_r [NUM_CH];
   logic [ACC_W-1:0]  acc_s [NUM_CH];
   logic [ACC_W-1:0]  acc_cur_s, upd_s;
   logic [WIDTH-1:0]  x_s;
   logic              last_s;
   logic              primed_r;

   logic              cad_meta_r, cad_sync_r, cad_filt_r, cad_filt_d_r;
   logic [FLT_W-1:0]  flt_cnt_r;
   logic [PER_W-1:0]  per_cnt_r;
   logic              seen_edge_r;

   // Free-running tick counter; tick pulses in the cycle the counter reads 0 after a wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r <= '0;
         tick_r     <= 1'b0;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_L'(1);
         tick_r     <= &tick_cnt_r;
      end
   end

   // Averaging FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         ch_r    <= '0;
      end else begin
         state_r <= state_s;
         ch_r    <= ch_s;
      end
   end

   // Next-state logic: idle until tick, scan channels one per cycle, then publish
   always_comb begin
      state_s = state_r;
      ch_s    = ch_r;
      case (state_r)
         ST_IDLE: begin
            if (tick_r) begin
               state_s = ST_RUN;
               ch_s    = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ch_r == CH_W'(NUM_CH - 1)) begin
               state_s = ST_DONE;
               ch_s    = '0;
            end else begin
               ch_s = ch_r + CH_W'(1);
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Shared datapath: select the active channel, then preload or blend
   always_comb begin
      acc_cur_s = '0;
      x_s       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         acc_cur_s = (ch_r == CH_W'(i)) ? acc_r[i] : acc_cur_s;
         x_s       = (ch_r == CH_W'(i)) ? sens_in[i*WIDTH +: WIDTH] : x_s;
      end
      upd_s  = primed_r ? (acc_cur_s - (acc_cur_s >> AVG_SHIFT) + ACC_W'(x_s))
                        : (ACC_W'(x_s) << AVG_SHIFT);
      last_s = (state_r == ST_RUN) && (ch_r == CH_W'(NUM_CH - 1));
      for (int i = 0; i < NUM_CH; i++) begin
         acc_s[i] = ((state_r == ST_RUN) && (ch_r == CH_W'(i))) ? upd_s : acc_r[i];
      end
   end

   // Accumulators and output registers; outputs load from the post-update values so
   // avg_out and avg_vld are visible together in the DONE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) acc_r[i] <= '0;
         avg_out  <= '0;
         avg_vld  <= 1'b0;
         primed_r <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) acc_r[i] <= acc_s[i];
         avg_vld  <= last_s;
         primed_r <= (state_r == ST_DONE) ? 1'b1 : primed_r;
         if (last_s) begin
            for (int i = 0; i < NUM_CH; i++) avg_out[i*WIDTH +: WIDTH] <= acc_s[i][ACC_W-1:AVG_SHIFT];
         end
      end
   end

   // Cadence synchroniser, stability filter and rising-edge pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cad_meta_r   <= 1'b0;
         cad_sync_r   <= 1'b0;
         cad_filt_r   <= 1'b0;
         cad_filt_d_r <= 1'b0;
         flt_cnt_r    <= '0;
         cad_edge     <= 1'b0;
      end else begin
         cad_meta_r   <= cadence_raw;
         cad_sync_r   <= cad_meta_r;
         cad_filt_d_r <= cad_filt_r;
         cad_edge     <= cad_filt_r & ~cad_filt_d_r;
         if (cad_sync_r != cad_filt_r) begin
            if (flt_cnt_r == FLT_W'(CAD_ST - 1)) begin
               cad_filt_r <= ~cad_filt_r;
               flt_cnt_r  <= '0;
            end else begin
               flt_cnt_r <= flt_cnt_r + FLT_W'(1);
            end
         end else begin
            flt_cnt_r <= '0;
         end
      end
   end

   // Period timer; an edge takes priority over the timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt_r    <= '0;
         seen_edge_r  <= 1'b0;
         cad_period   <= '1;
         not_pedaling <= 1'b1;
      end else if (cad_edge) begin
         if (seen_edge_r) begin
            cad_period   <= per_cnt_r;
            not_pedaling <= 1'b0;
         end
         seen_edge_r <= 1'b1;
         per_cnt_r   <= PER_W'(1);
      end else if (per_cnt_r == PER_W'(PED_TO)) begin
         not_pedaling <= 1'b1;
         cad_period   <= '1;
         seen_edge_r  <= 1'b0;
      end else begin
         per_cnt_r <= per_cnt_r + PER_W'(1);
      end
   end

endmodule
